// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters/UART and the transmit arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface uart_tx_arbiter_if;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [7:0]  uart_tx_data;
    logic        uart_start_tx;
    logic        uart_tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        sent;
    logic        timeout_err;

    modport slave (
        input  req, req_data, uart_tx_done,
        output ack, uart_tx_data, uart_start_tx, grant_id, busy, sent, timeout_err
    );

    modport master (
        output req, req_data, uart_tx_done,
        input  ack, uart_tx_data, uart_start_tx, grant_id, busy, sent, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from four requesters into one UART transmitter.
// Define UART_ARB_TIMEOUT_EN to add a START-state watchdog that aborts after TIMEOUT_CYCLES.
module uart_tx_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_e;

    state_e      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  ack_q, ack_d;
    logic [7:0]  data_q, data_d;
    logic        start_q, start_d;
    logic [1:0]  grant_q, grant_d;
    logic        busy_q, busy_d;
    logic        sent_q, sent_d;

    logic [1:0]  win;
    logic        any_req;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        terr_q, terr_d;
`else
    logic        unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // First requesting index in the order ptr, ptr+1, ptr+2, ptr+3.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        win   = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        any_req = found;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        grant_d = grant_q;
        ack_d   = 4'b0000;
        sent_d  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (any_req && bus.uart_tx_done) begin
                    data_d     = bus.req_data[{win, 3'b000} +: 8];
                    grant_d    = win;
                    ack_d[win] = 1'b1;
                    state_d    = START;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d      = 16'd0;
`endif
                end
            end
            START: begin
                if (!bus.uart_tx_done) begin
                    state_d = WAIT;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 16'd1;
                    // Abort once the START cycle count reaches the limit.
                    if (cnt_q + 16'd1 == TIMEOUT_CYCLES) begin
                        terr_d  = 1'b1;
                        ptr_d   = grant_q + 2'd1;
                        state_d = IDLE;
                    end
                end
`endif
            end
            WAIT: begin
                if (bus.uart_tx_done) begin
                    sent_d  = 1'b1;
                    ptr_d   = grant_q + 2'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Status outputs are registered copies of the next state.
        busy_d  = (state_d != IDLE);
        start_d = (state_d == START);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            ack_q   <= 4'b0000;
            data_q  <= 8'h00;
            start_q <= 1'b0;
            grant_q <= 2'd0;
            busy_q  <= 1'b0;
            sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            start_q <= start_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            sent_q  <= sent_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= 16'd0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end
    assign bus.timeout_err = terr_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.ack           = ack_q;
    assign bus.uart_tx_data  = data_q;
    assign bus.uart_start_tx = start_q;
    assign bus.grant_id      = grant_q;
    assign bus.busy          = busy_q;
    assign bus.sent          = sent_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; inputs change and outputs are sampled 1ns after posedge.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(.TIMEOUT_CYCLES(16'd16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".ack"},   32'(bus.ack), 32'h0);
        chk({tag, ".data"},  32'(bus.uart_tx_data), 32'h0);
        chk({tag, ".start"}, 32'(bus.uart_start_tx), 32'h0);
        chk({tag, ".grant"}, 32'(bus.grant_id), 32'h0);
        chk({tag, ".busy"},  32'(bus.busy), 32'h0);
        chk({tag, ".sent"},  32'(bus.sent), 32'h0);
        chk({tag, ".terr"},  32'(bus.timeout_err), 32'h0);
    endtask

    // One complete frame with req already set, arbiter idle and uart_tx_done high.
    task automatic do_frame(input string tag, input int id, input logic [7:0] byte_exp);
        tick();
        chk({tag, ".ack"},   32'(bus.ack), 32'(4'b0001 << id));
        chk({tag, ".grant"}, 32'(bus.grant_id), 32'(id));
        chk({tag, ".data"},  32'(bus.uart_tx_data), 32'(byte_exp));
        chk({tag, ".start"}, 32'(bus.uart_start_tx), 32'h1);
        bus.uart_tx_done = 1'b0;
        tick();
        chk({tag, ".start_off"}, 32'(bus.uart_start_tx), 32'h0);
        bus.uart_tx_done = 1'b1;
        tick();
        chk({tag, ".sent"}, 32'(bus.sent), 32'h1);
        chk({tag, ".idle"}, 32'(bus.busy), 32'h0);
    endtask

    initial begin
        int hi_cnt;
        int terr_cnt;
        reset = 1'b1;
        bus.req = 4'b0000;
        bus.req_data = 32'h0;
        bus.uart_tx_done = 1'b1;
        tick();
        tick();
        chk_reset_outputs("reset");
        reset = 1'b0;

        // Single requester, byte A5
        bus.req = 4'b0001;
        bus.req_data = 32'h0000_00A5;
        tick();
        chk("basic.ack",   32'(bus.ack), 32'h1);
        chk("basic.data",  32'(bus.uart_tx_data), 32'hA5);
        chk("basic.start", 32'(bus.uart_start_tx), 32'h1);
        chk("basic.grant", 32'(bus.grant_id), 32'h0);
        bus.req = 4'b0000;
        tick();
        chk("basic.ack_pulse", 32'(bus.ack), 32'h0);
        chk("basic.start_hold", 32'(bus.uart_start_tx), 32'h1);
        bus.uart_tx_done = 1'b0;
        tick();
        chk("basic.wait_start", 32'(bus.uart_start_tx), 32'h0);
        chk("basic.wait_busy", 32'(bus.busy), 32'h1);
        tick();
        chk("basic.no_early_sent", 32'(bus.sent), 32'h0);
        bus.uart_tx_done = 1'b1;
        tick();
        chk("basic.sent", 32'(bus.sent), 32'h1);
        chk("basic.busy_clr", 32'(bus.busy), 32'h0);
        tick();
        chk("basic.sent_pulse", 32'(bus.sent), 32'h0);

        // Round robin with all four requesting from ptr 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req = 4'b1111;
        bus.req_data = 32'h4332_2110;
        do_frame("rr0", 0, 8'h10);
        do_frame("rr1", 1, 8'h21);
        do_frame("rr2", 2, 8'h32);
        do_frame("rr3", 3, 8'h43);
        do_frame("rr4", 0, 8'h10);

        // Grant 2 moves ptr to 3; then 0 must beat 2 (wrap)
        bus.req = 4'b0100;
        do_frame("wrap_a", 2, 8'h32);
        bus.req = 4'b0101;
        do_frame("wrap_b", 0, 8'h10);
        do_frame("wrap_c", 2, 8'h32);

        // Data stays latched when req_data changes after grant
        bus.req = 4'b0010;
        bus.req_data = 32'h0000_3C00;
        tick();
        chk("hold.grant_data", 32'(bus.uart_tx_data), 32'h3C);
        bus.req = 4'b0000;
        bus.req_data = 32'hFFFF_FFFF;
        tick();
        chk("hold.start", 32'(bus.uart_tx_data), 32'h3C);
        bus.uart_tx_done = 1'b0;
        tick();
        chk("hold.wait", 32'(bus.uart_tx_data), 32'h3C);
        bus.uart_tx_done = 1'b1;
        tick();
        chk("hold.sent", 32'(bus.sent), 32'h1);
        chk("hold.sent_data", 32'(bus.uart_tx_data), 32'h3C);

        // START with uart_tx_done held high
        bus.req = 4'b0001;
        bus.req_data = 32'h0000_0077;
        tick();
        bus.req = 4'b0000;
        hi_cnt = 0;
        terr_cnt = 0;
`ifdef UART_ARB_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            if (bus.uart_start_tx) hi_cnt++;
            tick();
        end
        chk("wdog.start_cycles", 32'(hi_cnt), 32'd16);
        chk("wdog.start_off", 32'(bus.uart_start_tx), 32'h0);
        chk("wdog.terr", 32'(bus.timeout_err), 32'h1);
        chk("wdog.busy", 32'(bus.busy), 32'h0);
        chk("wdog.no_sent", 32'(bus.sent), 32'h0);
        tick();
        chk("wdog.terr_pulse", 32'(bus.timeout_err), 32'h0);
`else
        for (int i = 0; i < 1000; i++) begin
            if (bus.uart_start_tx) hi_cnt++;
            if (bus.timeout_err) terr_cnt++;
            tick();
        end
        chk("nowdog.start_cycles", 32'(hi_cnt), 32'd1000);
        chk("nowdog.terr", 32'(terr_cnt), 32'd0);
        chk("nowdog.busy", 32'(bus.busy), 32'h1);
        bus.uart_tx_done = 1'b0;
        tick();
        bus.uart_tx_done = 1'b1;
        tick();
        chk("nowdog.sent", 32'(bus.sent), 32'h1);
`endif

        // Reset in WAIT, then re-grant blocked until uart_tx_done returns
        tick();
        bus.req = 4'b0010;
        bus.req_data = 32'h0000_5500;
        tick();
        chk("rst_wait.ack", 32'(bus.ack), 32'h2);
        bus.uart_tx_done = 1'b0;
        tick();
        chk("rst_wait.in_wait", 32'(bus.uart_start_tx), 32'h0);
        reset = 1'b1;
        tick();
        chk_reset_outputs("rst_wait");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_wait.blocked_ack", 32'(bus.ack), 32'h0);
            chk("rst_wait.blocked_busy", 32'(bus.busy), 32'h0);
        end
        bus.uart_tx_done = 1'b1;
        tick();
        chk("rst_wait.regrant_ack", 32'(bus.ack), 32'h2);
        chk("rst_wait.regrant_data", 32'(bus.uart_tx_data), 32'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd50000, meaning START-state watchdog limit in clk cycles (used only when UART_ARB_TIMEOUT_EN is defined).
REQ-002 SHALL have ports, one clock and a synchronous active-high reset:
  clk  input  1  system clock; the only clock
  reset  input  1  synchronous, active-high reset
  req  input  4  per-requester byte request, level, bit k = requester k
  req_data  input  32  byte for requester k at bits [8k+7:8k]
  ack  output  4  one-cycle pulse: requester k's byte latched
  uart_tx_data  output  8  byte presented to the UART transmitter
  uart_start_tx  output  1  transmit request to the UART transmitter
  uart_tx_done  input  1  UART transmitter idle/done (high = idle)
  grant_id  output  2  index of the current or last granted requester
  busy  output  1  high in any state other than IDLE
  sent  output  1  one-cycle pulse: granted frame completed
  timeout_err  output  1  one-cycle pulse: START watchdog abort

Function
REQ-003 SHALL implement a 3-state FSM: IDLE, START, WAIT.
REQ-004 IDLE: when any req bit is 1 and uart_tx_done==1, SHALL at that edge select the winner, latch its req_data byte into uart_tx_data, set grant_id, pulse ack[winner] high for exactly the following cycle, and enter START.
REQ-005 IDLE with uart_tx_done==0 SHALL NOT grant (UART still finishing a frame).
REQ-006 Arbitration SHALL be round-robin: priority pointer ptr (2 bits) starts at 0; search order ptr, ptr+1, ptr+2, ptr+3 mod 4; the first requester with req=1 wins.
REQ-007 ptr SHALL update to (winner+1) mod 4 on leaving WAIT via completion or on a timeout abort; wrap 3->0.
REQ-008 START: uart_start_tx SHALL be 1; on sampling uart_tx_done==0, SHALL enter WAIT with uart_start_tx 0 from the next cycle.
REQ-009 WAIT: uart_start_tx SHALL be 0; on sampling uart_tx_done==1, SHALL pulse sent for one cycle and return to IDLE.
REQ-010 uart_tx_data SHALL hold stable from the grant edge until the next grant; it SHALL NOT follow req_data changes.
REQ-011 A requester holding req high after its ack SHALL be treated as a new request; it SHALL not win again while another requester is pending (fairness).
REQ-012 req changes while busy SHALL not affect the current transfer.
REQ-013 Minimum latency: req high in IDLE -> ack and uart_start_tx high 1 cycle later.
REQ-014 All outputs SHALL be registered; there SHALL be no combinational path from req or uart_tx_done to any output.

Reset
REQ-015 reset high at a clk edge SHALL force state IDLE, ptr 0, ack 0, uart_tx_data 0, uart_start_tx 0, grant_id 0, busy 0, sent 0, timeout_err 0, watchdog counter 0.
REQ-016 Reset mid-transfer SHALL abandon the transfer without sent/timeout_err pulses; the UART frame in flight completes on its own, and REQ-005 blocks re-grant until uart_tx_done==1.

Configuration
REQ-017 Macro UART_ARB_TIMEOUT_EN defined: a 16-bit counter SHALL clear on entering START and increment each START cycle; when it equals TIMEOUT_CYCLES with uart_tx_done still 1 (e.g. cts_n held high), SHALL drop uart_start_tx, pulse timeout_err one cycle, advance ptr per REQ-007, and return to IDLE with no sent pulse.
REQ-018 Macro not defined: no counter SHALL exist, START SHALL wait indefinitely, and timeout_err SHALL be constant 0.
REQ-019 WAIT SHALL have no watchdog in either configuration.

Verification
REQ-020 Reset then req=4'b0001, byte0=8'hA5 -> ack=4'b0001 one cycle later, uart_tx_data=8'hA5, uart_start_tx=1 until uart_tx_done falls, sent pulse once uart_tx_done rises, grant_id=0.
REQ-021 req=4'b1111 held, bytes 8'h10/8'h21/8'h32/8'h43 -> grants in order 0,1,2,3,0 with one sent per frame, no requester granted twice in a row.
REQ-022 ptr=3 (after grant to 2), req=4'b0101 -> requester 0 is granted before 2 (wrap 3->0).
REQ-023 UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, uart_tx_done held 1 -> uart_start_tx high 16 cycles, timeout_err one pulse, busy 0, no sent; without macro the same stimulus holds uart_start_tx high for 1000 cycles and timeout_err stays 0.
REQ-024 Reset asserted in WAIT while uart_tx_done=0, req=4'b0010 held -> all outputs at reset values next cycle; no grant until uart_tx_done returns 1, then ack=4'b0010.
REQ-025 req_data changed to 8'hFF after the grant of 8'h3C -> uart_tx_data stays 8'h3C through sent.
